// File: rtl/vga_timing_if.sv
// rtl/vga_timing_if.sv - raster timing bundle between vga_timing_gen and its pixel consumer
// The master drives the raster; the slave supplies the pixel-clock enable.
interface vga_timing_if #(
  parameter int XW = 10,
  parameter int YW = 10
);
  logic          en;
  logic [XW-1:0] pixel_x;
  logic [YW-1:0] pixel_y;
  logic          active;
  logic          line_start;
  logic          frame_start;
  logic          hsync;
  logic          vsync;
  logic          blank;
  logic          comp_sync;

  modport master (
    input  en,
    output pixel_x, pixel_y, active, line_start, frame_start,
    output hsync, vsync, blank, comp_sync
  );

  modport slave (
    output en,
    input  pixel_x, pixel_y, active, line_start, frame_start,
    input  hsync, vsync, blank, comp_sync
  );
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised raster timing generator with pipelined sync/blank
// Counters are undelayed; sync and blank pass through a PIPE-deep line matching the pixel pipeline.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int PIPE     = 2,
  parameter int XW       = 10,
  parameter int YW       = 10
) (
  input  logic         clk,
  input  logic         rst,
  vga_timing_if.master vif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [XW-1:0] H_LAST = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] H_VIS  = XW'(H_ACTIVE);
  localparam logic [XW-1:0] HS_BEG = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] HS_END = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [YW-1:0] V_LAST = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] V_VIS  = YW'(V_ACTIVE);
  localparam logic [YW-1:0] VS_BEG = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] VS_END = YW'(V_ACTIVE + V_FP + V_SYNC);

  // Line word order: {hsync, vsync, blank, comp_sync}, already in output polarity.
  localparam logic [3:0] IDLE = {~HS_POL, ~VS_POL, 1'b1, ~HS_POL};

  if (H_TOTAL > 2**XW || V_TOTAL > 2**YW ||
      H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 ||
      PIPE < 0 || PIPE > 15) begin : g_param_trap
    $error("vga_timing_gen: illegal timing parameters");
  end

  logic [XW-1:0] h, h_nxt;
  logic [YW-1:0] v, v_nxt;
  logic          active_r, active_nxt;
  logic          hs_a, vs_a, ls;
  logic [3:0]    raw;

  always_comb begin
    h_nxt = h;
    v_nxt = v;
    if (vif.en) begin
      if (h == H_LAST) begin
        h_nxt = '0;
        v_nxt = (v == V_LAST) ? '0 : v + YW'(1);
      end else begin
        h_nxt = h + XW'(1);
      end
    end
    active_nxt = (h_nxt < H_VIS) && (v_nxt < V_VIS);
  end

  // active is registered from the next-state counters so it lines up with h/v.
  always_ff @(posedge clk) begin
    if (rst) begin
      h        <= '0;
      v        <= '0;
      active_r <= 1'b1;
    end else begin
      h        <= h_nxt;
      v        <= v_nxt;
      active_r <= active_nxt;
    end
  end

  always_comb begin
    hs_a = (h >= HS_BEG) && (h < HS_END);
    vs_a = (v >= VS_BEG) && (v < VS_END);
    raw  = {hs_a ^ ~HS_POL, vs_a ^ ~VS_POL, ~active_r, (hs_a | vs_a) ^ ~HS_POL};
  end

  if (PIPE == 0) begin : g_direct
    assign vif.hsync     = raw[3];
    assign vif.vsync     = raw[2];
    assign vif.blank     = raw[1];
    assign vif.comp_sync = raw[0];
  end else begin : g_delay
    logic [3:0] dl [PIPE];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < PIPE; i++) dl[i] <= IDLE;
      end else if (vif.en) begin
        dl[0] <= raw;
        for (int i = 1; i < PIPE; i++) dl[i] <= dl[i-1];
      end
    end

    assign vif.hsync     = dl[PIPE-1][3];
    assign vif.vsync     = dl[PIPE-1][2];
    assign vif.blank     = dl[PIPE-1][1];
    assign vif.comp_sync = dl[PIPE-1][0];
  end

  assign ls              = vif.en & ~rst & (h == '0);
  assign vif.line_start  = ls;
  assign vif.frame_start = ls & (v == '0);
  assign vif.pixel_x     = h;
  assign vif.pixel_y     = v;
  assign vif.active      = active_r;

endmodule
